// File: rtl/rob_pkg.sv
// Shared types, sizes and helpers for the reorder buffer.
// Optional build macro used by rob.sv: ROB_COMMIT_BYPASS_EN.
package rob_pkg;

    // Geometry
    localparam int ROB_SIZE = 16;
    localparam int ROB_W    = $clog2(ROB_SIZE);
    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;

    typedef logic [ROB_W-1:0]  rob_idx_t;
    typedef logic [ROB_W:0]    rob_cnt_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_W-1:0]  reg_idx_t;

    // Occupancy value at which no further allocation is accepted
    localparam rob_cnt_t ROB_FULL_CNT = rob_cnt_t'(ROB_SIZE);

    // Advance a circular pointer; the index width makes it wrap at ROB_SIZE
    function automatic rob_idx_t rob_ptr_inc(input rob_idx_t ptr);
        return ptr + rob_idx_t'(1);
    endfunction

    // A committing branch whose resolved target differs from the prediction
    function automatic logic rob_mispredict(input logic  is_br,
                                            input data_t next_pc,
                                            input data_t pred_pc);
        return is_br && (next_pc != pred_pc);
    endfunction

endpackage : rob_pkg

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions.
// Allocates one entry per issue at the tail, captures CDB writebacks,
// retires the head entry in program order and raises a one-cycle flush
// when a committing branch turns out to be mispredicted.
// Build option: define ROB_COMMIT_BYPASS_EN to let a writeback aimed at the
// head commit in the same cycle (0-cycle writeback-to-commit); without it a
// writeback becomes committable one cycle later.
module rob
    import rob_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    // Issue / allocate
    input  logic              iss_valid,
    input  logic [REG_W-1:0]  iss_rd,
    input  logic              iss_is_br,
    input  logic [DATA_W-1:0] iss_pred_pc,
    output logic              full,
    output logic [ROB_W-1:0]  tail_pos,
    // CDB writeback
    input  logic              wb_valid,
    input  logic [ROB_W-1:0]  wb_pos,
    input  logic [DATA_W-1:0] wb_val,
    input  logic [DATA_W-1:0] wb_next_pc,
    // Operand lookups
    input  logic [ROB_W-1:0]  q1_pos,
    input  logic [ROB_W-1:0]  q2_pos,
    output logic              q1_rdy,
    output logic              q2_rdy,
    output logic [DATA_W-1:0] q1_val,
    output logic [DATA_W-1:0] q2_val,
    // Commit to the register file
    output logic              cm_valid,
    output logic [REG_W-1:0]  cm_rd,
    output logic [ROB_W-1:0]  cm_pos,
    output logic [DATA_W-1:0] cm_val,
    // Mispredict flush
    output logic              clear,
    output logic [DATA_W-1:0] clear_pc
);

    // Queue pointers and occupancy
    rob_idx_t head_q, head_d;
    rob_idx_t tail_q, tail_d;
    rob_cnt_t count_q, count_d;

    // Per-entry status bits, one bit per ROB position
    logic [ROB_SIZE-1:0] busy_q, busy_d;
    logic [ROB_SIZE-1:0] rdy_q, rdy_d;
    logic [ROB_SIZE-1:0] is_br_q, is_br_d;

    // Per-entry payload, parallel arrays indexed by ROB position
    reg_idx_t rd_q      [ROB_SIZE];
    reg_idx_t rd_d      [ROB_SIZE];
    data_t    pred_pc_q [ROB_SIZE];
    data_t    pred_pc_d [ROB_SIZE];
    data_t    val_q     [ROB_SIZE];
    data_t    val_d     [ROB_SIZE];
    data_t    next_pc_q [ROB_SIZE];
    data_t    next_pc_d [ROB_SIZE];

    // Effective view of the head entry (may include a same-cycle writeback)
    logic  head_rdy;
    data_t head_val;
    data_t head_next_pc;

    // Per-cycle actions
    logic do_alloc;
    logic do_wb;
    logic do_commit;
    logic do_flush;

    // full is taken from the registered count, so a commit in this cycle
    // cannot make room for an issue in the same cycle.
    assign full     = (count_q == ROB_FULL_CNT);
    assign tail_pos = tail_q;

    // Head entry as seen by the commit logic
    always_comb begin
        // NOTE: combinational blocks use blocking '='; only the clocked block
        // below assigns state, and it uses '<=' exclusively.
        head_rdy     = rdy_q[head_q];
        head_val     = val_q[head_q];
        head_next_pc = next_pc_q[head_q];
`ifdef ROB_COMMIT_BYPASS_EN
        // A result arriving for the head this cycle is committed straight
        // off the CDB instead of waiting for it to be written into the entry.
        if (wb_valid && (wb_pos == head_q)) begin
            head_rdy     = 1'b1;
            head_val     = wb_val;
            head_next_pc = wb_next_pc;
        end
`endif
    end

    // Commit and mispredict outputs; a stall suppresses both
    always_comb begin
        cm_valid = ready && (count_q != '0) && head_rdy;
        cm_rd    = rd_q[head_q];
        cm_pos   = head_q;
        cm_val   = head_val;
        clear    = cm_valid && rob_mispredict(is_br_q[head_q], head_next_pc,
                                              pred_pc_q[head_q]);
        clear_pc = head_next_pc;
    end

    // Operand lookups with same-cycle forwarding from the CDB; live during stalls
    always_comb begin
        q1_rdy = busy_q[q1_pos] && rdy_q[q1_pos];
        q1_val = val_q[q1_pos];
        if (wb_valid && (wb_pos == q1_pos)) begin
            q1_rdy = 1'b1;
            q1_val = wb_val;
        end
        q2_rdy = busy_q[q2_pos] && rdy_q[q2_pos];
        q2_val = val_q[q2_pos];
        if (wb_valid && (wb_pos == q2_pos)) begin
            q2_rdy = 1'b1;
            q2_val = wb_val;
        end
    end

    // Qualify this cycle's requests; nothing happens while ready is low
    always_comb begin
        do_alloc  = ready && iss_valid && !full;
        do_wb     = ready && wb_valid && busy_q[wb_pos];
        do_commit = cm_valid;
        do_flush  = clear;
    end

    // Next-state computation for pointers, status bits and payload
    always_comb begin
        // NOTE: every _d starts as a copy of its _q, so any path that does
        // not touch a field simply holds it and no latch can be inferred.
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        busy_d    = busy_q;
        rdy_d     = rdy_q;
        is_br_d   = is_br_q;
        rd_d      = rd_q;
        pred_pc_d = pred_pc_q;
        val_d     = val_q;
        next_pc_d = next_pc_q;

        if (do_flush) begin
            // Squash everything younger than the branch, including this
            // cycle's issue and writeback; the branch itself still commits.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            busy_d  = '0;
        end else begin
            // Writebacks only land on live entries
            if (do_wb) begin
                rdy_d[wb_pos]     = 1'b1;
                val_d[wb_pos]     = wb_val;
                next_pc_d[wb_pos] = wb_next_pc;
            end

            // Retire the head in program order
            if (do_commit) begin
                busy_d[head_q] = 1'b0;
                head_d         = rob_ptr_inc(head_q);
            end

            // Allocate at the tail; tail differs from head here because
            // allocation requires !full and commit requires count != 0
            if (do_alloc) begin
                busy_d[tail_q]    = 1'b1;
                rdy_d[tail_q]     = 1'b0;
                is_br_d[tail_q]   = iss_is_br;
                rd_d[tail_q]      = iss_rd;
                pred_pc_d[tail_q] = iss_pred_pc;
                tail_d            = rob_ptr_inc(tail_q);
            end

            // Occupancy: simultaneous alloc and commit cancel out
            case ({do_alloc, do_commit})
                2'b10:   count_d = count_q + rob_cnt_t'(1);
                2'b01:   count_d = count_q - rob_cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset (reset beats ready)
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            rdy_q   <= '0;
            is_br_q <= '0;
            // NOTE: the payload arrays are cleared too, because the commit,
            // flush and query outputs read them unconditionally and must all
            // be 0 straight after reset.
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_q[i]      <= '0;
                pred_pc_q[i] <= '0;
                val_q[i]     <= '0;
                next_pc_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
            is_br_q   <= is_br_d;
            rd_q      <= rd_d;
            pred_pc_q <= pred_pc_d;
            val_q     <= val_d;
            next_pc_q <= next_pc_d;
        end
    end

endmodule : rob

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based program-order model.
module tb_rob;

`ifdef ROB_COMMIT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int LAT = BYPASS ? 0 : 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_is_br;
    logic [31:0] iss_pred_pc;
    logic        full;
    logic [3:0]  tail_pos;
    logic        wb_valid;
    logic [3:0]  wb_pos;
    logic [31:0] wb_val;
    logic [31:0] wb_next_pc;
    logic [3:0]  q1_pos, q2_pos;
    logic        q1_rdy, q2_rdy;
    logic [31:0] q1_val, q2_val;
    logic        cm_valid;
    logic [4:0]  cm_rd;
    logic [3:0]  cm_pos;
    logic [31:0] cm_val;
    logic        clear;
    logic [31:0] clear_pc;

    rob dut (
        .clk(clk), .reset(reset), .ready(ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_is_br(iss_is_br),
        .iss_pred_pc(iss_pred_pc), .full(full), .tail_pos(tail_pos),
        .wb_valid(wb_valid), .wb_pos(wb_pos), .wb_val(wb_val),
        .wb_next_pc(wb_next_pc), .q1_pos(q1_pos), .q2_pos(q2_pos),
        .q1_rdy(q1_rdy), .q2_rdy(q2_rdy), .q1_val(q1_val), .q2_val(q2_val),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_pos(cm_pos), .cm_val(cm_val),
        .clear(clear), .clear_pc(clear_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model: in-flight entries in program order
    typedef struct {
        logic [4:0]  rd;
        bit          is_br;
        logic [31:0] pred_pc;
        logic [31:0] val;
        logic [31:0] next_pc;
        bit          rdy;
    } ent_t;

    ent_t m_q[$];
    int   m_head = 0;
    bit   exp_cm, exp_clear;
    int   cyc = 0;

    // Commits observed, for directed ordering/latency checks
    int obs_pos[$];
    int obs_rd[$];
    int obs_val[$];
    int obs_cyc[$];

    function automatic int offset_of(input logic [3:0] pos);
        return (int'(pos) - m_head + 16) % 16;
    endfunction

    task automatic q_model(input logic [3:0] pos, output logic r, output logic [31:0] v);
        int off;
        r = 1'b0;
        v = '0;
        off = offset_of(pos);
        if (wb_valid && wb_pos == pos) begin
            r = 1'b1;
            v = wb_val;
        end else if (off < m_q.size() && m_q[off].rdy) begin
            r = 1'b1;
            v = m_q[off].val;
        end
    endtask

    // Compare all outputs at the negedge against the model for current inputs
    task automatic eval();
        int          cnt;
        logic        hr, er;
        logic [31:0] hv, hn, ev;
        @(negedge clk);
        cnt = m_q.size();
        hr = 1'b0; hv = '0; hn = '0;
        if (cnt > 0) begin
            hr = m_q[0].rdy; hv = m_q[0].val; hn = m_q[0].next_pc;
            if (BYPASS && wb_valid && int'(wb_pos) == m_head) begin
                hr = 1'b1; hv = wb_val; hn = wb_next_pc;
            end
        end
        exp_cm    = ready && hr;
        exp_clear = exp_cm && m_q[0].is_br && (hn != m_q[0].pred_pc);
        check("full", 32'(full), 32'(cnt == 16));
        check("tail_pos", 32'(tail_pos), 32'((m_head + cnt) % 16));
        check("cm_valid", 32'(cm_valid), 32'(exp_cm));
        check("clear", 32'(clear), 32'(exp_clear));
        if (exp_cm) begin
            check("cm_pos", 32'(cm_pos), 32'(m_head));
            check("cm_rd", 32'(cm_rd), 32'(m_q[0].rd));
            check("cm_val", cm_val, hv);
        end
        if (exp_clear) check("clear_pc", clear_pc, hn);
        q_model(q1_pos, er, ev);
        check("q1_rdy", 32'(q1_rdy), 32'(er));
        if (er) check("q1_val", q1_val, ev);
        q_model(q2_pos, er, ev);
        check("q2_rdy", 32'(q2_rdy), 32'(er));
        if (er) check("q2_val", q2_val, ev);
        if (cm_valid === 1'b1) begin
            obs_pos.push_back(int'(cm_pos));
            obs_rd.push_back(int'(cm_rd));
            obs_val.push_back(int'(cm_val));
            obs_cyc.push_back(cyc);
        end
    endtask

    // Apply this cycle's effects to the model, then advance one clock
    task automatic tick();
        int   cnt, off;
        ent_t e;
        cnt = m_q.size();
        if (ready) begin
            if (exp_clear) begin
                m_q.delete();
                m_head = 0;
            end else begin
                if (wb_valid) begin
                    off = offset_of(wb_pos);
                    if (off < cnt) begin
                        e = m_q[off];
                        e.rdy = 1'b1; e.val = wb_val; e.next_pc = wb_next_pc;
                        m_q[off] = e;
                    end
                end
                if (exp_cm) begin
                    void'(m_q.pop_front());
                    m_head = (m_head + 1) % 16;
                end
                if (iss_valid && cnt < 16) begin
                    e.rd = iss_rd; e.is_br = iss_is_br; e.pred_pc = iss_pred_pc;
                    e.val = '0; e.next_pc = '0; e.rdy = 1'b0;
                    m_q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        ready = 1'b1; iss_valid = 1'b0; iss_rd = '0; iss_is_br = 1'b0; iss_pred_pc = '0;
        wb_valid = 1'b0; wb_pos = '0; wb_val = '0; wb_next_pc = '0;
        q1_pos = '0; q2_pos = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input bit br, input logic [31:0] pred);
        iss_valid = 1'b1; iss_rd = rd; iss_is_br = br; iss_pred_pc = pred;
    endtask

    task automatic wb(input logic [3:0] pos, input logic [31:0] val, input logic [31:0] npc);
        wb_valid = 1'b1; wb_pos = pos; wb_val = val; wb_next_pc = npc;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        m_q.delete();
        m_head = 0;
        exp_cm = 1'b0;
        exp_clear = 1'b0;
    endtask

    task automatic clear_obs();
        obs_pos.delete(); obs_rd.delete(); obs_val.delete(); obs_cyc.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, idx;
        bit found;

        // 1. Reset: every output 0
        do_reset();
        eval();
        check("rst_tail_pos", 32'(tail_pos), 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_cm_valid", 32'(cm_valid), 32'h0);
        check("rst_clear", 32'(clear), 32'h0);
        check("rst_cm_val", cm_val, 32'h0);
        check("rst_cm_rd", 32'(cm_rd), 32'h0);
        check("rst_clear_pc", clear_pc, 32'h0);
        check("rst_q1_val", q1_val, 32'h0);
        tick();

        // 2. Single issue, writeback, commit
        idle(); issue(5'd5, 1'b0, 32'h0); eval(); tick();
        clear_obs(); t0 = cyc;
        idle(); wb(4'd0, 32'h1234, 32'h0); eval(); tick();
        idle(); eval(); tick();
        check("t2_commits", 32'(obs_pos.size()), 32'd1);
        if (obs_pos.size() > 0) begin
            check("t2_cm_pos", 32'(obs_pos[0]), 32'd0);
            check("t2_cm_rd", 32'(obs_rd[0]), 32'd5);
            check("t2_cm_val", 32'(obs_val[0]), 32'h1234);
            check("t2_cm_cycle", 32'(obs_cyc[0]), 32'(t0 + LAT));
        end

        // 3. Fill, overflow drop, wraparound
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle(); issue(5'(i + 1), 1'b0, 32'h0); eval(); tick();
        end
        idle(); eval();
        check("t3_full", 32'(full), 32'd1);
        check("t3_tail", 32'(tail_pos), 32'd0);
        tick();
        idle(); issue(5'd30, 1'b0, 32'h0); eval(); tick();
        idle(); eval();
        check("t3_drop_full", 32'(full), 32'd1);
        check("t3_drop_tail", 32'(tail_pos), 32'd0);
        tick();
        // issue lands in the commit cycle, where full is still set
        idle(); wb(4'd0, 32'hAAAA, 32'h0); iss_valid = BYPASS; iss_rd = 5'd7; eval(); tick();
        idle(); iss_valid = !BYPASS; iss_rd = 5'd7; eval(); tick();
        idle(); eval();
        check("t3_after_commit_full", 32'(full), 32'd0);
        check("t3_after_commit_tail", 32'(tail_pos), 32'd0);
        tick();
        idle(); issue(5'd9, 1'b0, 32'h0); eval(); tick();
        idle(); eval();
        check("t3_wrap_tail", 32'(tail_pos), 32'd1);
        check("t3_wrap_full", 32'(full), 32'd1);
        tick();

        // 4. Out-of-order writeback, in-order commit
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); issue(5'(i + 1), 1'b0, 32'h0); eval(); tick();
        end
        clear_obs(); t0 = cyc;
        idle(); wb(4'd2, 32'h22, 32'h0); eval(); tick();
        idle(); wb(4'd1, 32'h11, 32'h0); eval(); tick();
        idle(); wb(4'd0, 32'h10, 32'h0); eval(); tick();
        repeat (3) begin idle(); eval(); tick(); end
        check("t4_commits", 32'(obs_pos.size()), 32'd3);
        for (int i = 0; i < obs_pos.size() && i < 3; i++) begin
            check("t4_order", 32'(obs_pos[i]), 32'(i));
            check("t4_cycle", 32'(obs_cyc[i]), 32'(t0 + 2 + LAT + i));
        end

        // 5. Mispredicted branch flush
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(); issue(5'(i + 1), i == 3, (i == 3) ? 32'h100 : 32'h0); eval(); tick();
        end
        idle(); wb(4'd0, 32'h1, 32'h0); eval(); tick();
        idle(); wb(4'd1, 32'h2, 32'h0); eval(); tick();
        idle(); wb(4'd2, 32'h3, 32'h0); eval(); tick();
        idle(); wb(4'd4, 32'h4444, 32'h0); eval(); tick();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            idle();
            if (k == 0) wb(4'd3, 32'h33, 32'h200);
            eval();
            if (cm_valid === 1'b1 && cm_pos == 4'd3) begin
                found = 1'b1;
                check("t5_clear", 32'(clear), 32'd1);
                check("t5_clear_pc", clear_pc, 32'h200);
            end
            tick();
        end
        if (!found) check("t5_branch_commit_seen", 32'd0, 32'd1);
        idle(); q1_pos = 4'd4; eval();
        check("t5_tail", 32'(tail_pos), 32'd0);
        check("t5_q4_rdy", 32'(q1_rdy), 32'd0);
        check("t5_cm_valid", 32'(cm_valid), 32'd0);
        tick();

        // 6. Stall with a ready head; forwarding during the stall
        do_reset();
        idle(); issue(5'd9, 1'b0, 32'h0); eval(); tick();
        idle(); issue(5'd10, 1'b0, 32'h0); eval(); tick();
        idle(); wb(4'd1, 32'h77, 32'h0); eval(); tick();
        idle(); wb(4'd0, 32'h66, 32'h0); eval(); tick();
        idle(); ready = 1'b0; eval();
        check("t6_stall_cm_valid", 32'(cm_valid), 32'd0);
        tick();
        idle(); ready = 1'b0; wb(4'd7, 32'hCAFE, 32'h0); q1_pos = 4'd7; eval();
        check("t6_fwd_rdy", 32'(q1_rdy), 32'd1);
        check("t6_fwd_val", q1_val, 32'hCAFE);
        check("t6_stall2_cm_valid", 32'(cm_valid), 32'd0);
        tick();
        idle(); eval();
        check("t6_resume_cm_valid", 32'(cm_valid), 32'd1);
        check("t6_resume_cm_pos", 32'(cm_pos), 32'(1 - LAT));
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            ready = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1)
                issue(5'($urandom), $urandom_range(0, 3) == 0, 32'($urandom_range(1, 4)) << 8);
            if ($urandom_range(0, 9) < 6) begin
                if (m_q.size() > 0 && $urandom_range(0, 9) < 8) begin
                    idx = $urandom_range(0, m_q.size() - 1);
                    wb(4'((m_head + idx) % 16), $urandom,
                       ($urandom_range(0, 15) == 0) ? 32'h900 : m_q[idx].pred_pc);
                end else begin
                    wb(4'($urandom), $urandom, $urandom);
                end
            end
            q1_pos = ($urandom_range(0, 3) == 0) ? wb_pos : 4'($urandom);
            q2_pos = 4'($urandom);
            eval();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rob
